ps2_rx_ctrl: RTL and testbench
==============================

Name: ps2_rx_ctrl

Overview:
Sequencing and flow-control wrapper around ps2_rx for the keyboard/mouse input path. Owns ps2_rx `en`. Buffers received bytes in a small FIFO for the CPU/bus side. Applies host clock-inhibit (open-drain low on PS/2 clock) when the FIFO nears full. Aborts and restarts ps2_rx on stuck frames, using a watchdog timer.

Parameters:
FIFO_DEPTH, 8, byte FIFO entries; power of 2, minimum 4
INHIBIT_CYCLES, 5000, minimum clock-low hold in clk cycles (100 us at 50 MHz)
TIMEOUT_CYCLES, 100000, max clk cycles from first PS/2 clock falling edge to rx_done (2 ms at 50 MHz)
RECOVER_CYCLES, 4, cycles rx_en is held low to reset ps2_rx after a timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset; asserted low
enable  in  1  software enable of the PS/2 receive path
ps2c_in  in  1  raw PS/2 clock line level (pad input), for activity detect
ps2c_oe  out  1  1 = drive PS/2 clock low (open-drain), 0 = release
rx_en  out  1  to ps2_rx.en
rx_done  in  1  from ps2_rx.done, 1-cycle pulse
rx_data  in  8  from ps2_rx.data, valid with rx_done
rd_en  in  1  pop request from consumer
rd_data  out  8  FIFO head, valid when empty=0 (show-ahead)
empty  out  1  FIFO empty
count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: byte dropped while FIFO full
timeout  out  1  sticky: frame watchdog fired
clr_status  in  1  clears overflow and timeout
state_o  out  3  current FSM state (debug)

Behaviour:
- Reset values: ps2c_oe=0, rx_en=0, empty=1, count=0, rd_data=0, overflow=0, timeout=0, state=DISABLED. All FIFO pointers are zero.
- ps2c_in passes through a 2-flop synchronizer. A falling edge of the synchronized signal sets `busy`. busy clears on rx_done, on leaving RUN, or on enable=0.
- FSM states:
  - DISABLED(0): rx_en=0, ps2c_oe=0. Go to RUN when enable=1.
  - RUN(1): rx_en=1, ps2c_oe=0. Watchdog counts while busy=1 and resets to 0 on rx_done.
    - Watchdog reaches TIMEOUT_CYCLES-1 -> RECOVER, set timeout.
    - Else, count>=FIFO_DEPTH-1 and busy=0 and rx_done=0 -> INHIBIT.
  - INHIBIT(2): rx_en=0, ps2c_oe=1, hold counter runs. Return to RUN only when hold counter >= INHIBIT_CYCLES-1 and count<=FIFO_DEPTH/2. ps2c_oe deasserts in the same cycle as the transition.
  - RECOVER(3): rx_en=0, ps2c_oe=0 for exactly RECOVER_CYCLES cycles, then RUN. busy is cleared.
  - enable=0 in any state -> DISABLED next cycle. An in-progress frame is abandoned; FIFO contents are kept.
- Watchdog and hold counter share one counter, cleared on every state change.
- FIFO write: rx_done=1 in RUN writes rx_data. Writes in any other state are ignored.
- FIFO full on write: byte dropped, overflow<=1, pointers unchanged.
- rd_en=1 while empty=1 is ignored. Simultaneous write and read when full: read pops and write is accepted, so count is unchanged and overflow is not set.
- Simultaneous write and read when empty: the write is stored; the read is ignored.
- Pointers wrap modulo FIFO_DEPTH. count = write count minus read count.
- Read latency: rd_data reflects the new head the cycle after rd_en.
- clr_status clears overflow and timeout. A same-cycle set event wins (flag stays 1).
- ps2_rx must see en=0 for at least RECOVER_CYCLES so its shift register and filter return to idle.

Decomposition:
- Shared package ps2_pkg holds:
  - typedef enum logic [2:0] {S_DISABLED, S_RUN, S_INHIBIT, S_RECOVER} ps2_ctrl_state_t
  - the default timing constants, as functions of a CLK_HZ constant
- One sub-module, ps2_byte_fifo, for a synchronous show-ahead FIFO with full, empty and count.
- The synchronizer, FSM and counters stay inline.

Test Plan:
1. ps2_rx (FILTER_STEPS=2) driven with frames for bytes 3C,5A,A5,C3,69,96, with enable=1 and no reads -> count reaches 6. FSM enters INHIBIT when count=7 or higher; with 6 bytes in an 8-deep FIFO it stays in RUN. Pop order is 3C,5A,A5,C3,69,96; empty=1 after the sixth pop.
2. Send 8 bytes with no reads -> after the 7th byte the FSM enters INHIBIT with ps2c_oe=1 and rx_en=0. Pop 4 bytes; ps2c_oe stays 1 until both INHIBIT_CYCLES have elapsed and count<=4, then RUN.
3. Force count=8 via a direct FIFO fill, then pulse rx_done with data 0x55 in RUN -> byte dropped, overflow=1, count=8. clr_status -> overflow=0.
4. Give one falling edge on ps2c_in and then stall the line -> after TIMEOUT_CYCLES the FSM goes RUN→RECOVER, timeout=1, and rx_en=0 for 4 cycles. Then RUN; a following clean frame 0x3C is received correctly.
5. Deassert enable mid-frame (after bit 4) -> DISABLED next cycle, rx_en=0, FIFO unchanged. Re-enable and send 0xA5 -> FIFO gains A5 only.
6. Assert rst low asynchronously mid-INHIBIT -> ps2c_oe=0, rx_en=0 and count=0 immediately, without waiting for a clk edge. Release rst -> the FSM returns to RUN when enable=1.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and default timing for the PS/2 receive path.
// Timing defaults are derived from the system clock rate.
package ps2_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef enum logic [2:0] {
    S_DISABLED = 3'd0,
    S_RUN      = 3'd1,
    S_INHIBIT  = 3'd2,
    S_RECOVER  = 3'd3
  } ps2_ctrl_state_t;

  function automatic int us_to_cycles(input int us);
    return (CLK_HZ / 1_000_000) * us;
  endfunction

  localparam int DEF_FIFO_DEPTH     = 8;
  localparam int DEF_INHIBIT_CYCLES = us_to_cycles(100);
  localparam int DEF_TIMEOUT_CYCLES = us_to_cycles(2000);
  localparam int DEF_RECOVER_CYCLES = 4;

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous show-ahead byte FIFO; rd_data is a registered copy of the head
// so it is defined (zero) out of reset and updates the cycle after a pop.
module ps2_byte_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_nxt;
  logic              do_wr, do_rd;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign do_rd  = rd_en & ~empty;
  assign do_wr  = wr_en & (~full | do_rd);
  assign drop   = wr_en & full & ~do_rd;
  assign rd_nxt = do_rd ? rd_ptr + PTR_ONE : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_nxt;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // The new head is the incoming byte only when it lands exactly at the next read slot.
      if (do_wr && (wr_ptr == rd_nxt))
        rd_data <= wr_data;
      else if (do_rd && (count > CNT_ONE))
        rd_data <= mem[rd_nxt];
    end
  end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// Flow-control wrapper around ps2_rx: owns its enable, buffers received bytes,
// inhibits the PS/2 clock near FIFO full and restarts ps2_rx on stuck frames.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        ps2c_in,
  output logic                        ps2c_oe,
  output logic                        rx_en,
  input  logic                        rx_done,
  input  logic [7:0]                  rx_data,
  input  logic                        rd_en,
  output logic [7:0]                  rd_data,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        timeout,
  input  logic                        clr_status,
  output logic [2:0]                  state_o
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int MAX_A   = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_MAX = (MAX_A > RECOVER_CYCLES) ? MAX_A : RECOVER_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REC_LAST  = CW'(RECOVER_CYCLES - 1);
  localparam logic [AW:0]   NEAR_FULL = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [AW:0]   HALF_CNT  = (AW+1)'(FIFO_DEPTH / 2);

  ps2_ctrl_state_t state;
  logic [2:0]      ps2c_sync;
  logic            ps2c_fall, busy;
  logic [CW-1:0]   cnt;
  logic            fifo_wr, fifo_full, fifo_drop;

  assign state_o   = state;
  assign ps2c_fall = ps2c_sync[2] & ~ps2c_sync[1];
  assign fifo_wr   = rx_done & (state == S_RUN);

  ps2_byte_fifo #(
    .DATA_W     (8),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (rx_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (fifo_full),
    .count   (count),
    .drop    (fifo_drop)
  );

  // Idle PS/2 clock is high, so the synchronizer resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ps2c_sync <= 3'b111;
    else      ps2c_sync <= {ps2c_sync[1:0], ps2c_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              overflow <= 1'b0;
    else if (fifo_drop)    overflow <= 1'b1;
    else if (clr_status)   overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_DISABLED;
      rx_en   <= 1'b0;
      ps2c_oe <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (clr_status) timeout <= 1'b0;
      if (!enable) begin
        state   <= S_DISABLED;
        rx_en   <= 1'b0;
        ps2c_oe <= 1'b0;
        cnt     <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_DISABLED: begin
            state <= S_RUN;
            rx_en <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b0;
          end
          S_RUN: begin
            if (busy && (cnt == TO_LAST)) begin
              state   <= S_RECOVER;
              rx_en   <= 1'b0;
              cnt     <= '0;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end else if ((count >= NEAR_FULL) && !busy && !rx_done) begin
              state   <= S_INHIBIT;
              rx_en   <= 1'b0;
              ps2c_oe <= 1'b1;
              cnt     <= '0;
            end else if (rx_done) begin
              cnt  <= '0;
              busy <= 1'b0;
            end else begin
              if (busy)      cnt  <= cnt + CNT_ONE;
              if (ps2c_fall) busy <= 1'b1;
            end
          end
          S_INHIBIT: begin
            // Hold counter saturates so a slow consumer cannot wrap it.
            if ((cnt >= INH_LAST) && (count <= HALF_CNT)) begin
              state   <= S_RUN;
              rx_en   <= 1'b1;
              ps2c_oe <= 1'b0;
              cnt     <= '0;
            end else if (cnt < INH_LAST) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_RECOVER: begin
            if (cnt == REC_LAST) begin
              state <= S_RUN;
              rx_en <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state   <= S_DISABLED;
            rx_en   <= 1'b0;
            ps2c_oe <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl; ps2_rx is emulated by PS/2 clock toggles
// followed by an rx_done pulse carrying the byte.
module tb_ps2_rx_ctrl;

  localparam int FIFO_DEPTH     = 8;
  localparam int INHIBIT_CYCLES = 20;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int RECOVER_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       ps2c_in = 1'b1;
  logic       ps2c_oe;
  logic       rx_en;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       timeout;
  logic       clr_status = 1'b0;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  ps2_rx_ctrl #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .INHIBIT_CYCLES (INHIBIT_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .RECOVER_CYCLES (RECOVER_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .ps2c_in    (ps2c_in),
    .ps2c_oe    (ps2c_oe),
    .rx_en      (rx_en),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .timeout    (timeout),
    .clr_status (clr_status),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset;
    rst = 1'b0; enable = 1'b0; rd_en = 1'b0; rx_done = 1'b0;
    clr_status = 1'b0; ps2c_in = 1'b1; rx_data = 8'h00;
    tick(2);
    rst = 1'b1; enable = 1'b1;
    tick(1);
  endtask

  task automatic send_frame(input logic [7:0] b);
    for (int i = 0; i < 11; i++) begin
      ps2c_in = 1'b0; tick(3);
      ps2c_in = 1'b1; tick(3);
    end
    tick(4);
    rx_data = b; rx_done = 1'b1; tick(1);
    rx_done = 1'b0; tick(1);
  endtask

  task automatic pop_check(input logic [7:0] exp, input string name);
    checks++;
    if (rd_data !== exp) begin errors++; $display("FAIL %s: rd_data got %h expected %h", name, rd_data, exp); end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; tick(2);
    checks++; if (ps2c_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b expected 0", ps2c_oe); end
    checks++; if (rx_en !== 1'b0) begin errors++; $display("FAIL rst_rx_en: got %b expected 0", rx_en); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data: got %h expected 00", rd_data); end
    checks++; if ({overflow, timeout} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected 00", {overflow, timeout}); end
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state_o); end
  endtask

  task automatic test_receive_order;
    logic [7:0] bytes [6];
    bytes = '{8'h3C, 8'h5A, 8'hA5, 8'hC3, 8'h69, 8'h96};
    apply_reset;
    checks++; if (state_o !== 3'd1 || rx_en !== 1'b1) begin errors++; $display("FAIL t1_run: state %0d rx_en %b expected 1 1", state_o, rx_en); end
    foreach (bytes[i]) send_frame(bytes[i]);
    tick(5);
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL t1_count: got %0d expected 6", count); end
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL t1_stay_run: got %0d expected 1", state_o); end
    foreach (bytes[i]) pop_check(bytes[i], "t1_pop");
    checks++; if (empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL t1_empty: empty %b count %0d expected 1 0", empty, count); end
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    checks++; if (empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL t1_rd_empty: empty %b count %0d expected 1 0", empty, count); end
  endtask

  task automatic test_inhibit;
    int c0;
    int budget;
    apply_reset;
    for (int i = 0; i < 7; i++) send_frame(8'h11 + 8'(i));
    c0 = cyc_cnt;
    checks++; if (state_o !== 3'd2 || ps2c_oe !== 1'b1 || rx_en !== 1'b0) begin errors++; $display("FAIL t2_enter: state %0d oe %b rx_en %b expected 2 1 0", state_o, ps2c_oe, rx_en); end
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL t2_count7: got %0d expected 7", count); end
    rx_data = 8'h18; rx_done = 1'b1; tick(1); rx_done = 1'b0;
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL t2_ignore_wr: got %0d expected 7", count); end
    pop_check(8'h11, "t2_pop"); pop_check(8'h12, "t2_pop");
    pop_check(8'h13, "t2_pop"); pop_check(8'h14, "t2_pop");
    checks++; if (ps2c_oe !== 1'b1 || count !== 4'd3) begin errors++; $display("FAIL t2_hold: oe %b count %0d expected 1 3", ps2c_oe, count); end
    budget = 0;
    while (state_o == 3'd2 && budget < 200) begin tick(1); budget++; end
    checks++; if (cyc_cnt - c0 !== INHIBIT_CYCLES) begin errors++; $display("FAIL t2_hold_len: got %0d expected %0d", cyc_cnt - c0, INHIBIT_CYCLES); end
    checks++; if (state_o !== 3'd1 || ps2c_oe !== 1'b0 || rx_en !== 1'b1) begin errors++; $display("FAIL t2_exit: state %0d oe %b rx_en %b expected 1 0 1", state_o, ps2c_oe, rx_en); end
  endtask

  task automatic test_overflow;
    apply_reset;
    for (int i = 0; i < 8; i++) begin rx_data = 8'hA0 + 8'(i); rx_done = 1'b1; tick(1); end
    checks++; if (count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL t3_full: count %0d ovf %b expected 8 0", count, overflow); end
    rx_data = 8'h77; rd_en = 1'b1; tick(1);
    checks++; if (count !== 4'd8 || overflow !== 1'b0) begin errors++; $display("FAIL t3_full_rw: count %0d ovf %b expected 8 0", count, overflow); end
    rx_data = 8'h55; rd_en = 1'b0; tick(1); rx_done = 1'b0;
    checks++; if (count !== 4'd8 || overflow !== 1'b1) begin errors++; $display("FAIL t3_drop: count %0d ovf %b expected 8 1", count, overflow); end
    for (int i = 1; i < 8; i++) pop_check(8'hA0 + 8'(i), "t3_pop");
    pop_check(8'h77, "t3_pop_last");
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL t3_empty: got %b expected 1", empty); end
    clr_status = 1'b1; tick(1); clr_status = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t3_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_timeout;
    int c0;
    int budget;
    int r;
    apply_reset;
    ps2c_in = 1'b0;
    c0 = cyc_cnt;
    budget = 0;
    while (state_o != 3'd3 && budget < TIMEOUT_CYCLES + 100) begin tick(1); budget++; end
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL t4_recover: state %0d expected 3", state_o); end
    checks++; if (cyc_cnt - c0 !== TIMEOUT_CYCLES + 3) begin errors++; $display("FAIL t4_latency: got %0d expected %0d", cyc_cnt - c0, TIMEOUT_CYCLES + 3); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL t4_flag: got %b expected 1", timeout); end
    ps2c_in = 1'b1;
    r = 0;
    while (state_o == 3'd3 && r < 20) begin
      checks++; if (rx_en !== 1'b0) begin errors++; $display("FAIL t4_rx_en_low: got %b expected 0", rx_en); end
      tick(1); r++;
    end
    checks++; if (r !== RECOVER_CYCLES) begin errors++; $display("FAIL t4_rec_len: got %0d expected %0d", r, RECOVER_CYCLES); end
    checks++; if (state_o !== 3'd1 || rx_en !== 1'b1) begin errors++; $display("FAIL t4_back_run: state %0d rx_en %b expected 1 1", state_o, rx_en); end
    send_frame(8'h3C);
    checks++; if (count !== 4'd1 || rd_data !== 8'h3C) begin errors++; $display("FAIL t4_frame: count %0d data %h expected 1 3c", count, rd_data); end
    clr_status = 1'b1; tick(1); clr_status = 1'b0;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL t4_clr: got %b expected 0", timeout); end
  endtask

  task automatic test_disable;
    apply_reset;
    send_frame(8'h3C);
    for (int i = 0; i < 5; i++) begin
      ps2c_in = 1'b0; tick(3);
      ps2c_in = 1'b1; tick(3);
    end
    ps2c_in = 1'b0; enable = 1'b0; tick(1);
    checks++; if (state_o !== 3'd0 || rx_en !== 1'b0) begin errors++; $display("FAIL t5_disabled: state %0d rx_en %b expected 0 0", state_o, rx_en); end
    rx_data = 8'hEE; rx_done = 1'b1; tick(1); rx_done = 1'b0;
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL t5_kept: got %0d expected 1", count); end
    ps2c_in = 1'b1; tick(2);
    enable = 1'b1; tick(1);
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL t5_reenable: got %0d expected 1", state_o); end
    send_frame(8'hA5);
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL t5_count: got %0d expected 2", count); end
    pop_check(8'h3C, "t5_pop_old");
    pop_check(8'hA5, "t5_pop_new");
  endtask

  task automatic test_async_reset;
    apply_reset;
    for (int i = 0; i < 7; i++) begin
      rx_data = 8'(i); rx_done = 1'b1; tick(1);
      rx_done = 1'b0; tick(1);
    end
    checks++; if (state_o !== 3'd2 || ps2c_oe !== 1'b1) begin errors++; $display("FAIL t6_inhibit: state %0d oe %b expected 2 1", state_o, ps2c_oe); end
    #3 rst = 1'b0;
    #1;
    checks++; if (ps2c_oe !== 1'b0 || rx_en !== 1'b0 || count !== 4'd0 || state_o !== 3'd0) begin
      errors++; $display("FAIL t6_async: oe %b rx_en %b count %0d state %0d expected 0 0 0 0", ps2c_oe, rx_en, count, state_o);
    end
    tick(1);
    rst = 1'b1; tick(1);
    checks++; if (state_o !== 3'd1 || rx_en !== 1'b1) begin errors++; $display("FAIL t6_release: state %0d rx_en %b expected 1 1", state_o, rx_en); end
  endtask

  initial begin
    #500_000;
    errors++;
    $display("FAIL global_timeout: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset;
    test_receive_order;
    test_inhibit;
    test_overflow;
    test_timeout;
    test_disable;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
